// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display bus in, decoded digits and status pulses out
interface seg_scan_decoder_if;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic [15:0] frame_digits;
    logic        frame_pulse;
    logic        pattern_err;
    logic        anode_err;
    modport master (
        output an, seg,
        input  digits, dp, digit_valid, frame_digits, frame_pulse, pattern_err, anode_err
    );
    modport slave (
        input  an, seg,
        output digits, dp, digit_valid, frame_digits, frame_pulse, pattern_err, anode_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: glitch-filters a multiplexed active-low 7-segment bus and rebuilds the four digits
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    logic [11:0]   s_q, s_d, cur;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    seen_q, seen_d, seen_new;
    logic [15:0]   digits_q, digits_d;
    logic [15:0]   frame_digits_q, frame_digits_d;
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    digit_valid_q, digit_valid_d;
    logic          frame_pulse_q, frame_pulse_d;
    logic          pattern_err_q, pattern_err_d;
    logic          anode_err_q, anode_err_d;
    logic          same, accept, idle, one_pos, pos_acc, code_ok;
    logic [3:0]    code;

    // stability counter: accept fires once, on the cycle the run reaches STABLE_CYCLES samples
    always_comb begin
        cur    = {bus.an, bus.seg};
        same   = (cur == s_q);
        s_d    = cur;
        cnt_d  = !same ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        accept = same && (cnt_q == CNT_ACC);
    end

    // segment decode of gfedcba (active-low); blank maps to F
    always_comb begin
        code    = 4'hF;
        code_ok = 1'b1;
        case (bus.seg[6:0])
            7'h40: code = 4'd0;
            7'h79: code = 4'd1;
            7'h24: code = 4'd2;
            7'h30: code = 4'd3;
            7'h19: code = 4'd4;
            7'h12: code = 4'd5;
            7'h02: code = 4'd6;
            7'h78: code = 4'd7;
            7'h00: code = 4'd8;
            7'h10: code = 4'd9;
            7'h7F: code = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    // per-position update, frame assembly and error classification
    always_comb begin
        idle           = (bus.an == 4'hF);
        one_pos        = $onehot(~bus.an);
        pos_acc        = accept && one_pos && code_ok;
        digits_d       = digits_q;
        dp_d           = dp_q;
        digit_valid_d  = digit_valid_q;
        seen_new       = seen_q;
        for (int i = 0; i < 4; i++) begin
            if (pos_acc && !bus.an[i]) begin
                digits_d[4*i +: 4] = code;
                dp_d[i]            = ~bus.seg[7];
                digit_valid_d[i]   = 1'b1;
                seen_new[i]        = 1'b1;
            end
        end
        frame_pulse_d  = (seen_new == 4'hF);
        seen_d         = frame_pulse_d ? 4'h0 : seen_new;
        frame_digits_d = frame_pulse_d ? digits_d : frame_digits_q;
        pattern_err_d  = accept && one_pos && !code_ok;
        anode_err_d    = accept && !idle && !one_pos;
    end

    // state registers; s_q resets to the idle bus value so the first real sample counts as a change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q            <= 12'hFFF;
            cnt_q          <= '0;
            seen_q         <= '0;
            digits_q       <= '0;
            frame_digits_q <= '0;
            dp_q           <= '0;
            digit_valid_q  <= '0;
            frame_pulse_q  <= 1'b0;
            pattern_err_q  <= 1'b0;
            anode_err_q    <= 1'b0;
        end else begin
            s_q            <= s_d;
            cnt_q          <= cnt_d;
            seen_q         <= seen_d;
            digits_q       <= digits_d;
            frame_digits_q <= frame_digits_d;
            dp_q           <= dp_d;
            digit_valid_q  <= digit_valid_d;
            frame_pulse_q  <= frame_pulse_d;
            pattern_err_q  <= pattern_err_d;
            anode_err_q    <= anode_err_d;
        end
    end

    assign bus.digits       = digits_q;
    assign bus.dp           = dp_q;
    assign bus.digit_valid  = digit_valid_q;
    assign bus.frame_digits = frame_digits_q;
    assign bus.frame_pulse  = frame_pulse_q;
    assign bus.pattern_err  = pattern_err_q;
    assign bus.anode_err    = anode_err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed checks of the segment scan decoder
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus ();
    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int fp_n, pe_n, ae_n, two_n, last_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        fp_n = 0; pe_n = 0; ae_n = 0; two_n = 0; last_edge = 0;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            fp_n += int'(bus.frame_pulse);
            pe_n += int'(bus.pattern_err);
            ae_n += int'(bus.anode_err);
            if (bus.frame_pulse || bus.pattern_err || bus.anode_err) last_edge = e;
            if (bus.digits[3:0] == 4'd2) two_n++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digits"}, 32'(bus.digits), 32'h0);
        chk({tag, "_frame"}, 32'(bus.frame_digits), 32'h0);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h0);
        chk({tag, "_valid"}, 32'(bus.digit_valid), 32'h0);
        chk({tag, "_pulses"}, 32'({bus.frame_pulse, bus.pattern_err, bus.anode_err}), 32'h0);
    endtask

    initial begin
        bus.an  = 4'hF;
        bus.seg = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        clr();
        for (int e = 1; e <= 4; e++) begin
            hold(4'hE, 8'hC0, 1);
            chk("single_pre_valid", 32'(bus.digit_valid), 32'h0);
        end
        hold(4'hE, 8'hC0, 1);
        chk("single_digit0", 32'(bus.digits[3:0]), 32'h0);
        chk("single_valid", 32'(bus.digit_valid), 32'h1);
        chk("single_dp0", 32'(bus.dp[0]), 32'h0);
        hold(4'hE, 8'hC0, 5);
        clr();
        hold(4'hE, 8'hF9, 10);
        hold(4'hD, 8'hA4, 10);
        hold(4'hB, 8'hB0, 10);
        chk("frame_none_early", 32'(fp_n), 32'd0);
        hold(4'h7, 8'h99, 10);
        chk("frame_one_pulse", 32'(fp_n), 32'd1);
        chk("frame_pulse_edge", 32'(last_edge), 32'd5);
        chk("frame_digits", 32'(bus.frame_digits), 32'h4321);
        chk("frame_dp", 32'(bus.dp), 32'h0);
        chk("frame_valid", 32'(bus.digit_valid), 32'hF);
        hold(4'hB, 8'h30, 10);
        chk("dp2_set", 32'(bus.dp), 32'h4);
        chk("dp2_digit", 32'(bus.digits[11:8]), 32'h3);
        hold(4'hE, 8'hC0, 10);
        chk("pre_glitch_digit0", 32'(bus.digits[3:0]), 32'h0);
        clr();
        hold(4'hE, 8'hA4, 3);
        hold(4'hE, 8'hF9, 10);
        chk("glitch_never_two", 32'(two_n), 32'd0);
        chk("glitch_digits", 32'(bus.digits), 32'h4321);
        chk("glitch_no_err", 32'(pe_n + ae_n), 32'd0);
        clr();
        hold(4'hE, 8'hFE, 10);
        chk("badpat_count", 32'(pe_n), 32'd1);
        chk("badpat_edge", 32'(last_edge), 32'd5);
        chk("badpat_digits", 32'(bus.digits), 32'h4321);
        chk("badpat_no_anode", 32'(ae_n), 32'd0);
        clr();
        hold(4'hC, 8'hC0, 10);
        chk("anode_count", 32'(ae_n), 32'd1);
        chk("anode_edge", 32'(last_edge), 32'd5);
        chk("anode_no_pat", 32'(pe_n), 32'd0);
        chk("anode_digits", 32'(bus.digits), 32'h4321);
        chk("anode_no_frame", 32'(fp_n), 32'd0);
        hold(4'hE, 8'h92, 8);
        hold(4'hD, 8'h82, 8);
        chk("midframe_digits", 32'(bus.digits), 32'h4365);
        rst     = 1'b1;
        bus.an  = 4'hF;
        bus.seg = 8'hFF;
        #1;
        chk_zero("async_rst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        hold(4'hE, 8'h92, 10);
        hold(4'hD, 8'h82, 10);
        hold(4'hB, 8'hF8, 10);
        chk("rst_frame_none_early", 32'(fp_n), 32'd0);
        chk("rst_valid_partial", 32'(bus.digit_valid), 32'h7);
        hold(4'h7, 8'h80, 10);
        chk("rst_frame_one_pulse", 32'(fp_n), 32'd1);
        chk("rst_frame_digits", 32'(bus.frame_digits), 32'h8765);
        chk("rst_valid_full", 32'(bus.digit_valid), 32'hF);
        clr();
        hold(4'hF, 8'hFF, 20);
        chk("idle_digits", 32'(bus.digits), 32'h8765);
        chk("idle_no_pulses", 32'(fp_n + pe_n + ae_n), 32'd0);
        hold(4'h7, 8'hFF, 10);
        chk("blank_digits", 32'(bus.digits), 32'hF765);
        chk("blank_valid3", 32'(bus.digit_valid[3]), 32'h1);
        chk("blank_no_err", 32'(pe_n + ae_n), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reads the multiplexed, active-low seven-segment bus (`an`/`seg`) that the stopwatch top level drives and reconstructs the four displayed digit values. It sits next to `stopwatch_main` on the same clock, as an on-chip display monitor and self-check. It is also a bench checker that turns raw segment patterns into BCD.

Each sample is glitch-filtered, decoded, stored per digit position and assembled into complete frames.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before an `{an,seg}` value is accepted; legal range ≥1.
- `clk`, in, 1: system clock, all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `an`, in, 4: digit enables, active-low. Bit i selects digit i; bit 0 is the rightmost digit.
- `seg`, in, 8: segments, active-low. `seg[0..6]` = a..g, `seg[7]` = dp.
- `digits`, out, 16: last accepted code per position, `digits[4i+3:4i]` = digit i.
- `dp`, out, 4: last accepted decimal point per position, active-high.
- `digit_valid`, out, 4: sticky; bit i is set once position i has been accepted since reset.
- `frame_digits`, out, 16: snapshot of `digits` taken when a frame completes.
- `frame_pulse`, out, 1: one-cycle pulse when all four positions have been accepted since the last frame.
- `pattern_err`, out, 1: one-cycle pulse when an accepted sample has an undecodable pattern.
- `anode_err`, out, 1: one-cycle pulse when an accepted sample has more than one `an` bit low.

## Operation
- **Sampling and stability:**
  - `s_reg <= {an,seg}` every cycle.
  - If `{an,seg} == s_reg`, `cnt` increments, saturating at `STABLE_CYCLES`; otherwise `cnt <= 0`.
  - `cnt` width is `$clog2(STABLE_CYCLES+1)`.
- **Accept:** an accept occurs when `{an,seg} == s_reg && cnt == STABLE_CYCLES-1`, so exactly once per stable run.
- **Anode classification on accept:**
  - `an == 4'b1111`: idle, no action.
  - Exactly one `an` bit low: position `idx`.
  - Otherwise: pulse `anode_err`; no other action.
- **Decode of `seg[6:0]` (gfedcba, active-low):**
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x7F (blank)→4'hF.
  - Any other pattern: pulse `pattern_err`. `digits`, `dp` and the frame mask are unchanged.
- **Valid accept of position `idx`:**
  - `digits[idx]` ← code.
  - `dp[idx]` ← `~seg[7]`.
  - `digit_valid[idx]` ← 1.
  - `seen[idx]` ← 1.
  - A repeat of the same position within a frame simply overwrites it.
- **Frame completion:** when the `seen` value after the update is 4'b1111:
  - `frame_pulse` = 1.
  - `frame_digits` ← `digits` including the current update.
  - `seen` ← 0 in the same cycle.
- **Errors:** `anode_err` and `pattern_err` never both assert in one cycle. Neither affects `seen` or `digit_valid`.

## Timing
- **Reset values:**
  - Outputs: `digits`, `frame_digits` = 0; `dp`, `digit_valid` = 0; all pulses 0.
  - Internal: `seen` = 0, `cnt` = 0, `s_reg` = 12'hFFF.
- **Acceptance latency:** edge 1 is the first rising edge at which a new `{an,seg}` value is present. If the value is held, the accept and all output updates happen at edge `STABLE_CYCLES+1` (edge 5 at the default).
- **Glitch rejection:** values held for ≤ `STABLE_CYCLES` edges are ignored. A change during the count restarts it.
- **Pulse width:** `frame_pulse`, `pattern_err` and `anode_err` are registered and last exactly one cycle. None re-fires while the input stays constant.
- **Reset mid-operation:** takes effect immediately, asynchronously. It discards a partial frame and a pending count. The first sample after release is treated as a change.
- **Minimum scan dwell:** a multiplexer must hold each digit for > `STABLE_CYCLES` cycles to be observed.

## Test plan
- **Single digit:** hold `an`=1110, `seg`=0xC0 (`STABLE_CYCLES`=4) → `digits[3:0]`=0, `digit_valid`=0001, `dp[0]`=0 exactly at edge 5, unchanged at edges 1–4.
- **Full frame:** scan `an`=1110/1101/1011/0111 with `seg`=0xF9/0xA4/0xB0/0x19, 10 cycles each → a single `frame_pulse` on the 4th accept, `frame_digits`=16'h4321, `dp`=0000. Then `dp` case: digit 2 with `seg`=0x30 → `dp[2]`=1, `digits[11:8]`=3.
- **Glitch:** hold `an`=1110, `seg`=0xA4 for 3 edges, then 0xF9 for 10 → `digits[3:0]` never 2, becomes 1. No error pulses.
- **Bad pattern:** `an`=1110, `seg`=0xFE → one `pattern_err` pulse at edge 5, `digits` unchanged. Then `an`=1100, `seg`=0xC0 → one `anode_err` pulse, `seen` unchanged.
- **Reset mid-frame:** accept digits 0 and 1, assert `rst` for 3 cycles → all outputs 0. Then a full 4-digit scan 5,6,7,8 → one `frame_pulse` with `frame_digits`=16'h8765 and no earlier pulse.
- **Blank/idle:** `an`=1111 for 20 cycles → no output change. `an`=0111, `seg`=0xFF → `digits[15:12]`=F, `digit_valid[3]`=1.
